// File: rtl/i2s_pcm_conv_master_if.sv
// I2S input / PCM output bundle for the I2S-to-PCM receiver.
// master = receiver side, slave = source/sink side.
`timescale 1ns/1ps
interface i2s_pcm_conv_master_if #(
  parameter int W = 32
);
  logic         BCK_I;
  logic         LRCK_I;
  logic         DATA_I;
  logic         MCLK_O;
  logic         BCK_O;
  logic         WCLK_O;
  logic [W-1:0] DATAL_O;
  logic [W-1:0] DATAR_O;

  modport master (
    input  BCK_I, LRCK_I, DATA_I,
    output MCLK_O, BCK_O, WCLK_O,
    output DATAL_O, DATAR_O
  );

  modport slave (
    output BCK_I, LRCK_I, DATA_I,
    input  MCLK_O, BCK_O, WCLK_O,
    input  DATAL_O, DATAR_O
  );
endinterface

// File: rtl/i2s_pcm_conv_master.sv
// I2S receiver oversampled by MCLK; emits signed L/R PCM words
// plus regenerated bit and word clocks.
`timescale 1ns/1ps
module i2s_pcm_conv_master #(
  parameter int PCM_BIT_WIDTH = 32
) (
  input  logic MCLK_I,
  input  logic NRST_I,
  i2s_pcm_conv_master_if.master bus
);
  localparam int W  = PCM_BIT_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic         bck_q, lr_q, dat_q, bck_prev_q;
  logic         first_q, first_d;
  logic         lr_prev_q, lr_prev_d;
  logic         l_act_q, l_act_d;
  logic         r_act_q, r_act_d;
  logic [CW-1:0] l_cnt_q, l_cnt_d;
  logic [CW-1:0] r_cnt_q, r_cnt_d;
  logic [W-1:0] l_sh_q, l_sh_d;
  logic [W-1:0] r_sh_q, r_sh_d;
  logic [W-1:0] hold_q, hold_d;
  logic         hold_vld_q, hold_vld_d;
  logic [W-1:0] datal_q, datal_d;
  logic [W-1:0] datar_q, datar_d;
  logic         wclk_q, wclk_d;
  logic         bck_rise;
  logic [W-1:0] l_word, r_word;

  assign bck_rise = bck_q & ~bck_prev_q;
  assign l_word   = {l_sh_q[W-2:0], dat_q};
  assign r_word   = {r_sh_q[W-2:0], dat_q};

  // Input stage: sample the I2S lines, delay BCK once more for edges
  always_ff @(posedge MCLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      bck_q      <= 1'b0;
      lr_q       <= 1'b0;
      dat_q      <= 1'b0;
      bck_prev_q <= 1'b0;
    end else begin
      bck_q      <= bus.BCK_I;
      lr_q       <= bus.LRCK_I;
      dat_q      <= bus.DATA_I;
      bck_prev_q <= bck_q;
    end
  end

  // Per-BCK-edge capture, completion and word-start logic
  always_comb begin
    first_d    = first_q;
    lr_prev_d  = lr_prev_q;
    l_act_d    = l_act_q;
    r_act_d    = r_act_q;
    l_cnt_d    = l_cnt_q;
    r_cnt_d    = r_cnt_q;
    l_sh_d     = l_sh_q;
    r_sh_d     = r_sh_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    datal_d    = datal_q;
    datar_d    = datar_q;
    wclk_d     = wclk_q;
    if (bck_rise) begin
      first_d   = 1'b1;
      lr_prev_d = lr_q;
      if (l_act_q) begin
        l_sh_d  = l_word;
        l_cnt_d = l_cnt_q + CW'(1);
        if (l_cnt_q == LAST) begin
          l_act_d    = 1'b0;
          hold_d     = l_word;
          hold_vld_d = 1'b1;
          wclk_d     = 1'b1;
        end
      end
      if (r_act_q) begin
        r_sh_d  = r_word;
        r_cnt_d = r_cnt_q + CW'(1);
        if (r_cnt_q == LAST) begin
          r_act_d = 1'b0;
          wclk_d  = 1'b0;
          // a right word without a preceding left word is not a pair
          if (hold_vld_q) begin
            datal_d    = hold_q;
            datar_d    = r_word;
            hold_vld_d = 1'b0;
          end
        end
      end
      // a start overrides any partial word of the same channel
      if (first_q && lr_prev_q && !lr_q) begin
        l_act_d = 1'b1;
        l_cnt_d = '0;
        l_sh_d  = '0;
      end
      if (first_q && !lr_prev_q && lr_q) begin
        r_act_d = 1'b1;
        r_cnt_d = '0;
        r_sh_d  = '0;
      end
    end
  end

  // Capture state and output registers
  always_ff @(posedge MCLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      first_q    <= 1'b0;
      lr_prev_q  <= 1'b0;
      l_act_q    <= 1'b0;
      r_act_q    <= 1'b0;
      l_cnt_q    <= '0;
      r_cnt_q    <= '0;
      l_sh_q     <= '0;
      r_sh_q     <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      datal_q    <= '0;
      datar_q    <= '0;
      wclk_q     <= 1'b0;
    end else begin
      first_q    <= first_d;
      lr_prev_q  <= lr_prev_d;
      l_act_q    <= l_act_d;
      r_act_q    <= r_act_d;
      l_cnt_q    <= l_cnt_d;
      r_cnt_q    <= r_cnt_d;
      l_sh_q     <= l_sh_d;
      r_sh_q     <= r_sh_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      datal_q    <= datal_d;
      datar_q    <= datar_d;
      wclk_q     <= wclk_d;
    end
  end

  assign bus.MCLK_O  = MCLK_I;
  assign bus.BCK_O   = bck_prev_q;
  assign bus.WCLK_O  = wclk_q;
  assign bus.DATAL_O = datal_q;
  assign bus.DATAR_O = datar_q;
endmodule

// File: tb/tb_i2s_pcm_conv_master.sv
// Directed bench for i2s_pcm_conv_master: W=32 and W=24
// instances fed from one 32-bit-slot I2S stream.
`timescale 1ns/1ps
module tb_i2s_pcm_conv_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bck = 1'b0;
  logic lrck = 1'b1;
  logic data = 1'b0;

  int vec = 0;
  int err = 0;
  bit skip0 = 1'b0;
  bit prev_lsb = 1'b0;
  logic [31:0] exp_l = '0;
  logic [31:0] exp_r = '0;

  always #1 clk = ~clk;

  i2s_pcm_conv_master_if #(.W(32)) bus32 ();
  i2s_pcm_conv_master_if #(.W(24)) bus24 ();

  assign bus32.BCK_I  = bck;
  assign bus32.LRCK_I = lrck;
  assign bus32.DATA_I = data;
  assign bus24.BCK_I  = bck;
  assign bus24.LRCK_I = lrck;
  assign bus24.DATA_I = data;

  i2s_pcm_conv_master #(.PCM_BIT_WIDTH(32)) dut32 (
    .MCLK_I(clk),
    .NRST_I(rst_n),
    .bus(bus32.master)
  );

  i2s_pcm_conv_master #(.PCM_BIT_WIDTH(24)) dut24 (
    .MCLK_I(clk),
    .NRST_I(rst_n),
    .bus(bus24.master)
  );

  task automatic bck_cycle(input bit lr, input bit d);
    @(negedge clk);
    bck = 1'b0;
    lrck = lr;
    data = d;
    @(negedge clk);
    bck = 1'b1;
  endtask

  task automatic send_slot(input bit lr, input logic [31:0] w);
    if (!skip0) bck_cycle(lr, prev_lsb);
    skip0 = 1'b0;
    for (int i = 1; i < 32; i++) bck_cycle(lr, w[32-i]);
    prev_lsb = w[0];
  endtask

  task automatic chk_zero(input string tag);
    vec++;
    if (bus32.DATAL_O !== 32'h0 || bus32.DATAR_O !== 32'h0 ||
        bus24.DATAL_O !== 24'h0 || bus24.DATAR_O !== 24'h0) begin
      err++;
      $display("FAIL %s: L32=%h R32=%h L24=%h R24=%h, need all 0",
               tag, bus32.DATAL_O, bus32.DATAR_O,
               bus24.DATAL_O, bus24.DATAR_O);
    end
  endtask

  task automatic do_pair(input logic [31:0] l, input logic [31:0] r,
                         input string tag);
    send_slot(1'b0, l);
    send_slot(1'b1, r);
    vec++;
    if (bus32.WCLK_O !== 1'b1 || bus32.DATAL_O !== exp_l) begin
      err++;
      $display("FAIL %s mid: wclk=%b L=%h, need wclk=1 L=%h",
               tag, bus32.WCLK_O, bus32.DATAL_O, exp_l);
    end
    bck_cycle(1'b0, r[0]);
    @(posedge clk); #0.5;
    vec++;
    if (bus32.DATAR_O !== exp_r || bus32.BCK_O !== 1'b0) begin
      err++;
      $display("FAIL %s lat1: R=%h bck_o=%b, need R=%h bck_o=0",
               tag, bus32.DATAR_O, bus32.BCK_O, exp_r);
    end
    @(posedge clk); #0.5;
    vec++;
    if (bus32.DATAL_O !== l || bus32.DATAR_O !== r) begin
      err++;
      $display("FAIL %s w32: L=%h R=%h, need L=%h R=%h",
               tag, bus32.DATAL_O, bus32.DATAR_O, l, r);
    end
    vec++;
    if (bus32.WCLK_O !== 1'b0 || bus32.BCK_O !== 1'b1) begin
      err++;
      $display("FAIL %s lat2: wclk=%b bck_o=%b, need wclk=0 bck_o=1",
               tag, bus32.WCLK_O, bus32.BCK_O);
    end
    vec++;
    if (bus24.DATAL_O !== l[31:8] || bus24.DATAR_O !== r[31:8]) begin
      err++;
      $display("FAIL %s w24: L=%h R=%h, need L=%h R=%h",
               tag, bus24.DATAL_O, bus24.DATAR_O, l[31:8], r[31:8]);
    end
    exp_l = l;
    exp_r = r;
    skip0 = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int j = 0; j < 40; j++) bck_cycle(((j / 32) % 2) == 1, j[0]);
    chk_zero("reset_data");
    vec++;
    if (bus32.WCLK_O !== 1'b0 || bus32.BCK_O !== 1'b0 ||
        bus24.WCLK_O !== 1'b0 || bus24.BCK_O !== 1'b0) begin
      err++;
      $display("FAIL reset_clk: wclk=%b bck_o=%b, need 0 0",
               bus32.WCLK_O, bus32.BCK_O);
    end
    @(posedge clk); #0.5;
    vec++;
    if (bus32.MCLK_O !== 1'b1) begin
      err++;
      $display("FAIL reset_mclk_hi: got %b need 1", bus32.MCLK_O);
    end
    @(negedge clk); #0.5;
    vec++;
    if (bus32.MCLK_O !== 1'b0) begin
      err++;
      $display("FAIL reset_mclk_lo: got %b need 0", bus32.MCLK_O);
    end
  endtask

  task automatic test_startup();
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 24; j++) bck_cycle(1'b1, 1'b1);
    prev_lsb = 1'b1;
    chk_zero("startup_idle");
    vec++;
    if (bus32.WCLK_O !== 1'b0) begin
      err++;
      $display("FAIL startup_wclk: got %b need 0", bus32.WCLK_O);
    end
  endtask

  task automatic test_basic();
    do_pair(32'h12345678, 32'hEDCBA987, "basic");
  endtask

  task automatic test_signed();
    do_pair(32'h80000000, 32'h7FFFFFFF, "extreme1");
    do_pair(32'hFFFFFFFF, 32'h00000001, "extreme2");
  endtask

  task automatic test_short_word();
    do_pair({24'hABCDEF, 8'hFF}, {24'h654321, 8'h00}, "short");
  endtask

  task automatic test_midreset();
    skip0 = 1'b1;
    for (int i = 1; i < 16; i++) bck_cycle(1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midrst_now");
    for (int j = 0; j < 5000; j++) bck_cycle(((j / 32) % 2) == 1, 1'b1);
    chk_zero("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 24; j++) bck_cycle(1'b0, 1'b1);
    prev_lsb = 1'b1;
    skip0 = 1'b0;
    send_slot(1'b1, 32'hDEADBEEF);
    chk_zero("midrst_lone_right");
    exp_l = '0;
    exp_r = '0;
    do_pair(32'h0F1E2D3C, 32'hC3D2E1F0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_startup();
    test_basic();
    test_signed();
    test_short_word();
    test_midreset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  task automatic test_back_to_back();
    do_pair(32'h00000000, 32'hFFFFFFFF, "b2b1");
    do_pair(32'hA5A5A5A5, 32'h5A5A5A5A, "b2b2");
  endtask
endmodule
